spram_init: RTL and testbench

- Parametrised single-port synchronous memory with registered address/read path and a built-in initialisation sequencer.
- After reset, or on request, the sequencer walks every location and writes a fill pattern (zero, or address-identity lookup) before the port is released.
- Serves as the general lookup-table/scratch memory for lab datapaths.
- Read latency is selectable, and read-during-write ordering is defined.

---
 rtl/lab_mem_pkg.sv | 14 +
 rtl/spram_core.sv | 48 ++++
 rtl/spram_init.sv | 157 +++++++++++++++
 tb/tb_spram_init.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lab_mem_pkg.sv
// Shared constants and state encoding for the lab scratch/lookup memory.
package lab_mem_pkg;

    localparam int INIT_ZERO       = 0;
    localparam int INIT_IDENT      = 1;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/spram_core.sv
// Bare single-port array with a registered read result; out-of-range reads
// are forced to zero by the caller through i_rzero.
module spram_core
    import lab_mem_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 64,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_rzero,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // Array write port; the array itself is deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register: holds its value until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            if (i_rzero) begin
                r_q <= '0;
            end else if ((RDW_MODE == RDW_WRITE_FIRST) && i_we) begin
                r_q <= i_wdata;
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/spram_init.sv
// Single-port memory with a self-initialising fill sequencer, request gating,
// optional output register stage and out-of-range flagging.
module spram_init
    import lab_mem_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int INIT_MODE = 1,
    parameter int OUT_REG   = 0,
    parameter int RDW_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              oor
);

    localparam int                CW   = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_v1;
    logic              r_o1;

    logic              w_fill;
    logic              w_in_range;
    logic              w_acc;
    logic              w_core_we;
    logic              w_core_re;
    logic [ADDR_W-1:0] w_core_addr;
    logic [DATA_W-1:0] w_core_wdata;
    logic [DATA_W-1:0] w_core_rdata;
    logic [DATA_W-1:0] w_fill_data;

    // Fill pattern: counter truncated to DATA_W bits, zero-extended when wider.
    always_comb begin
        w_fill_data = '0;
        if (INIT_MODE == INIT_IDENT) begin
            w_fill_data[CW-1:0] = r_cnt[CW-1:0];
        end else begin
            w_fill_data = '0;
        end
    end

    // init has priority over a same-cycle access, which is then dropped.
    assign w_fill       = (r_state == ST_FILL);
    assign w_in_range   = (32'(addr) < 32'(DEPTH));
    assign w_acc        = !w_fill && en && !init;
    assign w_core_we    = w_fill || (w_acc && we && w_in_range);
    assign w_core_re    = w_acc && !we;
    assign w_core_addr  = w_fill ? r_cnt : addr;
    assign w_core_wdata = w_fill ? w_fill_data : wdata;

    spram_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_core_we),
        .i_re    (w_core_re),
        .i_rzero (!w_in_range),
        .i_addr  (w_core_addr),
        .i_wdata (w_core_wdata),
        .o_rdata (w_core_rdata)
    );

    // Fill sequencer: walks 0..DEPTH-1 then releases the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (r_cnt == LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (init) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // First pipeline stage, aligned with the core read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_o1 <= 1'b0;
        end else begin
            r_v1 <= w_core_re;
            r_o1 <= w_acc && !w_in_range;
        end
    end

    assign busy = r_busy;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              r_v2;
            logic              r_o2;
            logic [DATA_W-1:0] r_d2;

            // Optional second stage; data only advances with a valid read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_o2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    r_o2 <= r_o1;
                    if (r_v1) begin
                        r_d2 <= w_core_rdata;
                    end
                end
            end

            assign rvalid = r_v2;
            assign oor    = r_o2;
            assign rdata  = r_d2;
        end else begin : g_noreg
            assign rvalid = r_v1;
            assign oor    = r_o1;
            assign rdata  = w_core_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_spram_init.sv
// Directed plus randomized bench for spram_init: two instances (default and
// DEPTH=48/zero-fill/output-register) share stimulus against a countdown model.
module tb_spram_init;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       init  = 1'b0;
    logic       en    = 1'b0;
    logic       we    = 1'b0;
    logic [5:0] addr  = 6'd0;
    logic [3:0] wdata = 4'd0;

    logic [3:0] rdata0, rdata1;
    logic       rvalid0, rvalid1, busy0, busy1, oor0, oor1;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state
    int         f0, f1;
    logic [3:0] m0 [64];
    logic [3:0] m1 [48];
    logic       p0v, p0o, p1av, p1ao, p1bv, p1bo;
    logic [3:0] p0d, p1ad, p1bd, h0, h1;

    always #5 clk = ~clk;

    spram_init dut0 (
        .clk(clk), .rst_n(rst_n), .init(init), .en(en), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0), .oor(oor0)
    );

    spram_init #(
        .DATA_W(4), .ADDR_W(6), .DEPTH(48), .INIT_MODE(0), .OUT_REG(1), .RDW_MODE(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init(init), .en(en), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .oor(oor1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refill0();
        for (int i = 0; i < 64; i++) m0[i] = 4'(i % 16);
    endtask

    task automatic refill1();
        for (int i = 0; i < 48; i++) m1[i] = 4'h0;
    endtask

    // One clock: drive at negedge, advance the model over the coming edge, check at next negedge.
    task automatic step(input logic e, input logic w, input int a, input logic [3:0] d, input logic ini);
        logic acc0, acc1;
        en = e; we = w; addr = 6'(a); wdata = d; init = ini;
        acc0 = (f0 == 0) && e && !ini;
        p0v  = acc0 && !w;
        p0o  = acc0 && (a >= 64);
        p0d  = (a < 64) ? m0[a] : 4'h0;
        if (acc0 && w && (a < 64)) m0[a] = d;
        acc1 = (f1 == 0) && e && !ini;
        p1bv = p1av; p1bo = p1ao; p1bd = p1ad;
        p1av = acc1 && !w;
        p1ao = acc1 && (a >= 48);
        p1ad = (a < 48) ? m1[a] : 4'h0;
        if (acc1 && w && (a < 48)) m1[a] = d;
        if (f0 > 0) f0--;
        else if (ini) begin f0 = 64; refill0(); end
        if (f1 > 0) f1--;
        else if (ini) begin f1 = 48; refill1(); end
        @(negedge clk);
        if (p0v)  h0 = p0d;
        if (p1bv) h1 = p1bd;
        chk("rvalid0", 32'(rvalid0), 32'(p0v));
        chk("oor0",    32'(oor0),    32'(p0o));
        chk("rdata0",  32'(rdata0),  32'(h0));
        chk("busy0",   32'(busy0),   32'(f0 > 0));
        chk("rvalid1", 32'(rvalid1), 32'(p1bv));
        chk("oor1",    32'(oor1),    32'(p1bo));
        chk("rdata1",  32'(rdata1),  32'(h1));
        chk("busy1",   32'(busy1),   32'(f1 > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 4'h0, 1'b0);
    endtask

    // Assert reset now (mid-cycle is allowed), verify flushed outputs, release at a negedge.
    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; we = 1'b0; init = 1'b0;
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rdata0",  32'(rdata0),  32'd0);
        chk("rst_oor0",    32'(oor0),    32'd0);
        chk("rst_busy0",   32'(busy0),   32'd1);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata1",  32'(rdata1),  32'd0);
        chk("rst_oor1",    32'(oor1),    32'd0);
        chk("rst_busy1",   32'(busy1),   32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold_rvalid0", 32'(rvalid0), 32'd0);
            chk("rst_hold_rvalid1", 32'(rvalid1), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        f0 = 64; f1 = 48;
        p0v = 1'b0; p0o = 1'b0; p0d = 4'h0;
        p1av = 1'b0; p1ao = 1'b0; p1ad = 4'h0;
        p1bv = 1'b0; p1bo = 1'b0; p1bd = 4'h0;
        h0 = 4'h0; h1 = 4'h0;
        refill0(); refill1();
    endtask

    // Count busy-high cycles from reset release (release sample included).
    task automatic busy_count(input string tag);
        int c0, c1;
        c0 = 32'(busy0); c1 = 32'(busy1);
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b0, 0, 4'h0, 1'b0);
            if (busy0) c0++;
            if (busy1) c1++;
        end
        chk({tag, "_busy_len0"}, 32'(c0), 32'd64);
        chk({tag, "_busy_len1"}, 32'(c1), 32'd48);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // 1: fill length and identity contents
        busy_count("t1");
        step(1'b1, 1'b0, 5, 4'h0, 1'b0);
        chk("t1_rd5", 32'(rdata0), 32'h5);
        step(1'b1, 1'b0, 20, 4'h0, 1'b0);
        chk("t1_rd20", 32'(rdata0), 32'h4);
        chk("t1_rd5_oreg", 32'(rdata1), 32'h0);
        idle(2);

        // 2: write then immediate read, latency 1 and 2
        step(1'b1, 1'b1, 10, 4'hA, 1'b0);
        step(1'b1, 1'b0, 10, 4'h0, 1'b0);
        chk("t2_rvalid0", 32'(rvalid0), 32'd1);
        chk("t2_rdata0", 32'(rdata0), 32'hA);
        chk("t2_rvalid1_early", 32'(rvalid1), 32'd0);
        idle(1);
        chk("t2_rvalid1", 32'(rvalid1), 32'd1);
        chk("t2_rdata1", 32'(rdata1), 32'hA);
        idle(1);

        // 3: back-to-back reads through the output register
        step(1'b1, 1'b1, 2, 4'h9, 1'b0);
        step(1'b1, 1'b0, 1, 4'h0, 1'b0);
        step(1'b1, 1'b0, 2, 4'h0, 1'b0);
        chk("t3_b2b0", 32'(rdata1), 32'h0);
        step(1'b1, 1'b0, 3, 4'h0, 1'b0);
        chk("t3_b2b1", 32'(rdata1), 32'h9);
        chk("t3_b2b1_rv", 32'(rvalid1), 32'd1);
        idle(1);
        chk("t3_b2b2", 32'(rdata1), 32'h0);
        chk("t3_b2b2_rv", 32'(rvalid1), 32'd1);
        idle(2);

        // 4: out-of-range read and dropped write on the DEPTH=48 instance
        step(1'b1, 1'b0, 50, 4'h0, 1'b0);
        chk("t4_rd50_dut0", 32'(rdata0), 32'h2);
        idle(1);
        chk("t4_oor1", 32'(oor1), 32'd1);
        chk("t4_rdata_oor1", 32'(rdata1), 32'h0);
        step(1'b1, 1'b1, 50, 4'hF, 1'b0);
        step(1'b1, 1'b0, 34, 4'h0, 1'b0);
        chk("t4_rd34_dut0", 32'(rdata0), 32'h2);
        step(1'b1, 1'b0, 50, 4'h0, 1'b0);
        chk("t4_rd50_after_wr", 32'(rdata0), 32'hF);
        idle(2);

        // 5: init with same-cycle access drops it and refills
        step(1'b1, 1'b1, 3, 4'h7, 1'b0);
        step(1'b1, 1'b0, 3, 4'h0, 1'b1);
        chk("t5_dropped", 32'(rvalid0), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd1);
        idle(66);
        step(1'b1, 1'b0, 3, 4'h0, 1'b0);
        chk("t5_rd3_dut0", 32'(rdata0), 32'h3);
        idle(1);
        chk("t5_rd3_dut1", 32'(rdata1), 32'h0);

        // 6: reset mid-fill, then reset with reads in flight
        step(1'b0, 1'b0, 0, 4'h0, 1'b1);
        idle(20);
        do_reset();
        busy_count("t6a");
        step(1'b1, 1'b0, 7, 4'h0, 1'b0);
        en = 1'b1; we = 1'b0; addr = 6'd9;
        #2;
        do_reset();
        busy_count("t6b");

        // Randomized traffic including occasional init pulses
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2 == 1, int'($urandom % 64),
                 4'($urandom), ($urandom % 64) == 0);
        end
        idle(70);
        en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
